// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : icache_assoc
// Purpose  : Set-associative, read-only instruction cache. Hits return the
//            word in the same cycle; misses fetch a whole block from
//            instruction memory and fill the victim way. The victim is the
//            lowest invalid way, otherwise the true-LRU way.
// Option   : ICACHE_PERF_CNT_EN adds saturating hit_count/miss_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module icache_assoc #(
   parameter int ADDR_W          = 32,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int SETS            = 8,
   parameter int WAYS            = 2
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic                                        read,
   input  logic [ADDR_W-1:0]                           address,
   input  logic                                        flush,
   output logic [31:0]                                 instruction,
   output logic                                        busywait,
   output logic                                        mem_read,
   output logic [ADDR_W-$clog2(4*WORDS_PER_BLOCK)-1:0] mem_address,
   input  logic [32*WORDS_PER_BLOCK-1:0]               mem_readdata,
   input  logic                                        mem_busywait
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0]                                 hit_count,
   output logic [31:0]                                 miss_count
`endif
);

   localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
   localparam int BLK_W = ADDR_W - 2 - OFF_W;
   localparam int LRU_W = WAYS * WAYS;

   typedef enum logic [1:0] {IDLE, MEM_READ, CACHE_WRITE, FLUSH} state_t;

   state_t                               state_q, state_d;
   logic [SETS-1:0][WAYS-1:0]            valid_q, valid_d;
   // Per set, bit [i*WAYS+j] set means way i was used more recently than way j.
   logic [SETS-1:0][LRU_W-1:0]           lru_q, lru_d;
   logic [BLK_W-1:0]                     blk_q, blk_d;
   logic [32*WORDS_PER_BLOCK-1:0]        fill_q, fill_d;
   logic [TAG_W-1:0]                     tag_mem  [SETS][WAYS];
   logic [32*WORDS_PER_BLOCK-1:0]        data_mem [SETS][WAYS];

   logic [OFF_W-1:0]                     off;
   logic [IDX_W-1:0]                     idx;
   logic [TAG_W-1:0]                     tag;
   logic                                 hit;
   logic [WAY_W-1:0]                     hit_way;
   logic [WAY_W-1:0]                     victim;
   logic                                 fill_we;
   logic [32*WORDS_PER_BLOCK-1:0]        hit_block;

   assign off = address[2 +: OFF_W];
   assign idx = address[2+OFF_W +: IDX_W];
   assign tag = address[ADDR_W-1 -: TAG_W];

   // Make way w the most recently used: its row all ones, its column cleared.
   function automatic logic [LRU_W-1:0] lru_touch(input logic [LRU_W-1:0] m,
                                                  input logic [WAY_W-1:0] w);
      logic [LRU_W-1:0] r;
      r = m;
      for (int j = 0; j < WAYS; j++) begin
         r[int'(w)*WAYS + j] = (j != int'(w));
         r[j*WAYS + int'(w)] = 1'b0;
      end
      return r;
   endfunction

   // Tag lookup across the ways of the addressed set.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (read && valid_q[idx][w] && (tag_mem[idx][w] == tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Victim: lowest invalid way, otherwise the way older than all others.
   always_comb begin
      logic found;
      found  = 1'b0;
      victim = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found && !valid_q[idx][w]) begin
            victim = WAY_W'(w);
            found  = 1'b1;
         end
      end
      for (int w = 0; w < WAYS; w++) begin
         if (!found && (lru_q[idx][w*WAYS +: WAYS] == '0)) begin
            victim = WAY_W'(w);
            found  = 1'b1;
         end
      end
   end

   // Next-state, valid, LRU and miss-buffer logic.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      lru_d   = lru_q;
      blk_d   = blk_q;
      fill_d  = fill_q;
      fill_we = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush) begin
               state_d = FLUSH;
            end else if (read && !hit) begin
               state_d = MEM_READ;
               blk_d   = address[ADDR_W-1:2+OFF_W];
            end else if (hit) begin
               lru_d[idx] = lru_touch(lru_q[idx], hit_way);
            end
         end
         MEM_READ: begin
            if (!mem_busywait) begin
               fill_d  = mem_readdata;
               state_d = CACHE_WRITE;
            end
         end
         CACHE_WRITE: begin
            fill_we             = 1'b1;
            valid_d[idx][victim] = 1'b1;
            lru_d[idx]          = lru_touch(lru_q[idx], victim);
            state_d             = IDLE;
         end
         FLUSH: begin
            valid_d = '0;
            lru_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         valid_q <= '0;
         lru_q   <= '0;
         blk_q   <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         lru_q   <= lru_d;
         blk_q   <= blk_d;
         fill_q  <= fill_d;
      end
   end

   // Tag and data arrays are not reset; valid bits guard them.
   always_ff @(posedge clock) begin
      if (reset && fill_we) begin
         tag_mem[idx][victim]  <= tag;
         data_mem[idx][victim] <= fill_q;
      end
   end

   assign hit_block = data_mem[idx][hit_way];

   // Core and memory outputs; forced quiet while reset is asserted.
   always_comb begin
      instruction = '0;
      busywait    = 1'b0;
      mem_read    = 1'b0;
      mem_address = '0;
      if (reset) begin
         case (state_q)
            IDLE: begin
               busywait = flush | (read & ~hit);
               if (hit) instruction = hit_block[{off, 5'd0} +: 32];
            end
            MEM_READ: begin
               busywait    = 1'b1;
               mem_read    = 1'b1;
               mem_address = blk_q;
            end
            default: busywait = 1'b1;
         endcase
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   // Saturating counters of IDLE hits and of misses entering MEM_READ.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (state_q == IDLE && hit && hit_count_q != '1)
         hit_count_d = hit_count_q + 32'd1;
      if (state_q == IDLE && !flush && read && !hit && miss_count_q != '1)
         miss_count_d = miss_count_q + 32'd1;
   end

   // Counter registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_assoc
// Purpose  : Directed self-checking bench for icache_assoc (2-way, 8 sets,
//            4 words per block). Memory answers after 3 cycles of mem_read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_assoc;

   logic         clock;
   logic         reset;
   logic         read;
   logic [31:0]  address;
   logic         flush;
   logic [31:0]  instruction;
   logic         busywait;
   logic         mem_read;
   logic [27:0]  mem_address;
   logic [127:0] mem_readdata;
   logic         mem_busywait;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;
`endif

   int passed = 0;
   int total  = 0;

   icache_assoc dut (
      .clock        (clock),
      .reset        (reset),
      .read         (read),
      .address      (address),
      .flush        (flush),
      .instruction  (instruction),
      .busywait     (busywait),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .hit_count    (hit_count),
      .miss_count   (miss_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory model: word k of the block at byte address B is 0xA0000000|B|k,
   // data valid on the third cycle of mem_read.
   logic [1:0]  lat_cnt;
   logic [31:0] blk_byte;
   always @(posedge clock) begin
      if (!mem_read) lat_cnt <= 2'd0;
      else           lat_cnt <= lat_cnt + 2'd1;
   end
   assign blk_byte     = {mem_address, 4'h0};
   assign mem_busywait = !(mem_read && lat_cnt == 2'd2);
   assign mem_readdata = {32'hA000_0000 | blk_byte | 32'd3,
                          32'hA000_0000 | blk_byte | 32'd2,
                          32'hA000_0000 | blk_byte | 32'd1,
                          32'hA000_0000 | blk_byte};

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One fetch: count stalled cycles, return the word, commit the final
   // (hit) cycle with one more edge, then drop read.
   task automatic fetch(input logic [31:0] a, output int cycles, output logic [31:0] instr,
                        output int mem_cycles, output logic addr_ok);
      read       = 1'b1;
      address    = a;
      cycles     = 0;
      mem_cycles = 0;
      addr_ok    = 1'b1;
      #1;
      while (busywait && cycles < 30) begin
         if (mem_read) begin
            mem_cycles++;
            if (mem_address != a[31:4]) addr_ok = 1'b0;
         end
         cycles++;
         tick();
      end
      instr = instruction;
      tick();
      read = 1'b0;
   endtask

   int          cyc;
   int          mcyc;
   logic        aok;
   logic [31:0] ins;

   initial begin
      reset   = 1'b0;
      read    = 1'b0;
      address = '0;
      flush   = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_busywait", {63'd0, busywait}, 64'd0);
      chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
      chk("rst_mem_address", {36'd0, mem_address}, 64'd0);
      chk("rst_instruction", {32'd0, instruction}, 64'd0);
      reset = 1'b1;
      tick();

      // Idle with no request
      chk("idle_busywait", {63'd0, busywait}, 64'd0);
      chk("idle_instruction", {32'd0, instruction}, 64'd0);

      // Cold miss at 0x100
      fetch(32'h100, cyc, ins, mcyc, aok);
      chk("miss100_cycles", cyc, 5);
      chk("miss100_memcycles", mcyc, 3);
      chk("miss100_memaddr", {63'd0, aok}, 64'd1);
      chk("miss100_word", {32'd0, ins}, 64'hA000_0100);

      // Hit at 0x104, same cycle
      read    = 1'b1;
      address = 32'h104;
      #1;
      chk("hit104_busywait", {63'd0, busywait}, 64'd0);
      chk("hit104_mem_read", {63'd0, mem_read}, 64'd0);
      chk("hit104_word", {32'd0, instruction}, 64'hA000_0101);
      tick();
      read = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
      chk("perf_miss_count", {32'd0, miss_count}, 64'd1);
      chk("perf_hit_count", {32'd0, hit_count}, 64'd2);
`endif

      // Flush with a simultaneous miss
      read    = 1'b1;
      address = 32'h0;
      flush   = 1'b1;
      #1;
      chk("flush_req_mem_read", {63'd0, mem_read}, 64'd0);
      tick();
      flush = 1'b0;
      read  = 1'b0;
      #1;
      chk("flush_state_busywait", {63'd0, busywait}, 64'd1);
      chk("flush_state_mem_read", {63'd0, mem_read}, 64'd0);
      tick();
      fetch(32'h000, cyc, ins, mcyc, aok);
      chk("postflush_000_cycles", cyc, 5);
      chk("postflush_000_word", {32'd0, ins}, 64'hA000_0000);

      // LRU replacement in set 0
      fetch(32'h080, cyc, ins, mcyc, aok);
      chk("fill080_cycles", cyc, 5);
      chk("fill080_word", {32'd0, ins}, 64'hA000_0080);
      fetch(32'h008, cyc, ins, mcyc, aok);
      chk("touch000_cycles", cyc, 0);
      chk("touch000_word", {32'd0, ins}, 64'hA000_0002);
      fetch(32'h10C, cyc, ins, mcyc, aok);
      chk("miss10C_cycles", cyc, 5);
      chk("miss10C_word", {32'd0, ins}, 64'hA000_0103);
      fetch(32'h004, cyc, ins, mcyc, aok);
      chk("keep000_cycles", cyc, 0);
      chk("keep000_word", {32'd0, ins}, 64'hA000_0001);
      fetch(32'h080, cyc, ins, mcyc, aok);
      chk("evict080_cycles", cyc, 5);

      // Reset in the middle of a miss
      read    = 1'b1;
      address = 32'h200;
      tick();
      chk("midmiss_mem_read", {63'd0, mem_read}, 64'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      read  = 1'b0;
      #1;
      chk("postrst_mem_read", {63'd0, mem_read}, 64'd0);
      chk("postrst_busywait", {63'd0, busywait}, 64'd0);
      tick();
      fetch(32'h080, cyc, ins, mcyc, aok);
      chk("postrst_080_cycles", cyc, 5);
      chk("postrst_080_word", {32'd0, ins}, 64'hA000_0080);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 Parameter ADDR_W, 32, byte-address width.
REQ-002 Parameter WORDS_PER_BLOCK, 4, 32-bit words per block (power of two, >=2).
REQ-003 Parameter SETS, 8, number of sets (power of two, >=2).
REQ-004 Parameter WAYS, 2, associativity (power of two, 1..8).
REQ-005 Port clock input 1, single clock; all state changes on posedge.
REQ-006 Port reset input 1, synchronous, active-low.
REQ-007 Port read input 1, fetch request from core.
REQ-008 Port address input ADDR_W, fetch byte address; held stable by core while busywait=1.
REQ-009 Port flush input 1, single-cycle request to invalidate all lines.
REQ-010 Port instruction output 32, fetched word.
REQ-011 Port busywait output 1, core stall.
REQ-012 Port mem_read output 1, block read request to instruction memory.
REQ-013 Port mem_address output ADDR_W-log2(4*WORDS_PER_BLOCK), block address.
REQ-014 Port mem_readdata input 32*WORDS_PER_BLOCK, returned block, word 0 in LSBs.
REQ-015 Port mem_busywait input 1, memory busy; data valid in the cycle it is low while mem_read=1.

Function
REQ-016 Address split SHALL be: bits[1:0] ignored, word offset next log2(WORDS_PER_BLOCK) bits, index next log2(SETS) bits, tag the remaining upper bits.
REQ-017 Hit SHALL be combinational: read=1, any way of indexed set valid with matching tag; at most one way matches.
REQ-018 On hit in IDLE: busywait=0 and instruction=matching word in the same cycle (zero-cycle latency).
REQ-019 FSM states SHALL be IDLE, MEM_READ, CACHE_WRITE, FLUSH.
REQ-020 IDLE->FLUSH when flush=1 (flush has priority over a simultaneous miss); IDLE->MEM_READ when read=1 and no hit; else stay IDLE.
REQ-021 MEM_READ: mem_read=1, mem_address=address block bits, busywait=1; ->CACHE_WRITE when mem_busywait=0, else stay.
REQ-022 CACHE_WRITE: mem_read=0, busywait=1; victim way written with mem_readdata, tag, valid=1; ->IDLE, where the access then hits (miss penalty = memory latency + 2 cycles).
REQ-023 FLUSH: busywait=1, all valid bits cleared, LRU state cleared; ->IDLE after one cycle.
REQ-024 flush asserted outside IDLE SHALL be ignored; the core re-asserts it.
REQ-025 Victim selection: lowest-numbered invalid way in set; if none, least-recently-used way.
REQ-026 LRU SHALL be true LRU per set, updated on every hit in IDLE and on every fill, the touched way becoming most-recent.
REQ-027 read=0 in IDLE: busywait=0, no state change, no LRU update; instruction=0.
REQ-028 mem_address SHALL stay constant for the whole MEM_READ residency.

Reset
REQ-029 reset=0 at a clock edge, in any state including mid-miss: next state IDLE, all valid bits 0, LRU 0, counters 0.
REQ-030 Outputs during and after reset: busywait=0, mem_read=0, mem_address=0, instruction=0; tag/data arrays not cleared.
REQ-031 A memory response arriving after reset aborted a miss SHALL be ignored.

Configuration
REQ-032 Macro ICACHE_PERF_CNT_EN defined: outputs hit_count and miss_count (32 bits each) are present; hit_count increments on each IDLE cycle with a hit, miss_count on each IDLE->MEM_READ transition; both saturate at all-ones.
REQ-033 Macro ICACHE_PERF_CNT_EN undefined: those ports and counters are absent; all other behaviour unchanged.

Verification
REQ-034 Reset, then read=1 address=0x100, memory latency 3 -> busywait=1 for 5 cycles, mem_address=0x10, then instruction=word 0 of block, busywait=0.
REQ-035 Repeat address=0x104 after fill -> hit, busywait=0 same cycle, instruction=word 1, no mem_read.
REQ-036 WAYS=2, SETS=8: fill 0x000, 0x080, touch 0x000, then miss 0x100 -> way holding 0x080 replaced; 0x000 still hits, 0x080 misses.
REQ-037 flush=1 with read=1 miss in IDLE -> FLUSH for one cycle, no mem_read; then 0x000 misses.
REQ-038 reset=0 during MEM_READ -> next cycle IDLE, mem_read=0, busywait=0; previously filled address misses.
REQ-039 With ICACHE_PERF_CNT_EN: scenario REQ-034 then REQ-035 -> miss_count=1, hit_count=2 (post-fill hit plus REQ-035 hit).
